// File: rtl/dm_store_resp_if.sv
// dm_store_resp_if: CPU data-port and backing-SRAM signals of dm_store_resp.
interface dm_store_resp_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [31:0]       m_data_addr;
  logic [31:0]       m_data_wdata;
  logic [3:0]        m_data_byteen;
  logic              m_data_ren;
  logic [31:0]       m_data_rdata;
  logic              m_stall;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_be;
  logic              sram_gnt;
  logic              sram_rvalid;
  logic [31:0]       sram_rdata;
  logic              stb_empty;

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_data_ren,
    input  sram_gnt, sram_rvalid, sram_rdata,
    output m_data_rdata, m_stall, sram_req, sram_we, sram_addr, sram_wdata, sram_be, stb_empty
  );

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_data_ren,
    output sram_gnt, sram_rvalid, sram_rdata,
    input  m_data_rdata, m_stall, sram_req, sram_we, sram_addr, sram_wdata, sram_be, stb_empty
  );
endinterface

// File: rtl/dm_store_resp.sv
// dm_store_resp: data-port responder with a background-drained store buffer and a load FSM.
// Optional store merging into the tail-most entry is enabled by defining DM_STB_MERGE_EN.
module dm_store_resp #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input logic            clk,
  input logic            reset,
  dm_store_resp_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} rd_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } stb_entry_t;

  rd_state_e         state_q, state_d;
  stb_entry_t        stb_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       rdata_q;
  logic              empty_q;

  logic [ADDR_W-1:0] waddr_c;
  logic              store_req_c, full_c, nonempty_c, hazard_c;
  logic              rd_issue_c, pop_c, push_c, merge_c;
  logic              unused_c;

  assign waddr_c     = bus.m_data_addr[ADDR_W+1:2];
  assign unused_c    = ^{bus.m_data_addr[31:ADDR_W+2], bus.m_data_addr[1:0]};
  assign store_req_c = |bus.m_data_byteen;
  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign nonempty_c  = (count_q != '0);

  // Load hazard: any valid entry (offset from head below count) holds the load's word
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) && (stb_q[PTR_W'(i)].addr == waddr_c))
        hazard_c = 1'b1;
    end
  end

  // Read FSM next state and SRAM port arbitration: an issuing read beats the drain
  always_comb begin
    state_d        = state_q;
    rd_issue_c     = 1'b0;
    pop_c          = 1'b0;
    bus.sram_req   = 1'b0;
    bus.sram_we    = 1'b1;
    bus.sram_addr  = stb_q[head_q].addr;
    bus.sram_wdata = stb_q[head_q].data;
    bus.sram_be    = stb_q[head_q].be;
    case (state_q)
      IDLE: begin
        if (bus.m_data_ren && !hazard_c) begin
          rd_issue_c    = 1'b1;
          bus.sram_req  = 1'b1;
          bus.sram_we   = 1'b0;
          bus.sram_addr = waddr_c;
          bus.sram_be   = 4'hF;
          if (bus.sram_gnt) state_d = RD_WAIT;
        end else if (nonempty_c) begin
          bus.sram_req = 1'b1;
          pop_c        = bus.sram_gnt;
        end
      end
      RD_WAIT: if (bus.sram_rvalid) state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DM_STB_MERGE_EN
  logic [PTR_W-1:0] last_c;
  logic             merge_do_c;
  assign last_c     = tail_q - PTR_W'(1);
  // The tail-most entry cannot absorb a store if it is the head leaving this cycle
  assign merge_c    = store_req_c && nonempty_c && (stb_q[last_c].addr == waddr_c)
                      && !(pop_c && (count_q == CNT_W'(1)));
  assign merge_do_c = merge_c && !bus.m_stall;
`else
  assign merge_c = 1'b0;
`endif

  assign bus.m_stall      = (bus.m_data_ren && (state_q != RD_DONE)) || (store_req_c && full_c && !merge_c);
  assign push_c           = store_req_c && !bus.m_stall && !merge_c;
  assign count_d          = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  assign bus.m_data_rdata = rdata_q;
  assign bus.stb_empty    = empty_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      if (push_c) tail_q <= tail_q + PTR_W'(1);
      if (pop_c)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      if ((state_q == RD_WAIT) && bus.sram_rvalid) rdata_q <= bus.sram_rdata;
    end
  end

  // Entry payloads need no reset: validity is carried by head/count
  always_ff @(posedge clk) begin
    if (push_c) begin
      stb_q[tail_q] <= '{addr: waddr_c, data: bus.m_data_wdata, be: bus.m_data_byteen};
    end
`ifdef DM_STB_MERGE_EN
    else if (merge_do_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.m_data_byteen[b]) stb_q[last_c].data[8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
      end
      stb_q[last_c].be <= stb_q[last_c].be | bus.m_data_byteen;
    end
`endif
  end
endmodule

// File: tb/tb_dm_store_resp.sv
// tb_dm_store_resp: vector table, directed corner sequences and a random load/store run
// checked against a flat memory model of the CPU's program-order view.
module tb_dm_store_resp;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_store_resp_if #(.ADDR_W(ADDR_W)) sif();
  dm_store_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(sif.slave));

  logic        auto_sram = 1'b0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0, a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] m_rdata = '0, a_rdata = '0;
  assign sif.sram_gnt    = auto_sram ? a_gnt    : m_gnt;
  assign sif.sram_rvalid = auto_sram ? a_rvalid : m_rvalid;
  assign sif.sram_rdata  = auto_sram ? a_rdata  : m_rdata;

  int n_vec = 0, n_mis = 0;
  int pushes = 0, pops = 0;
  logic [31:0] sm [8];
  logic [31:0] gm [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ren, input logic gnt, input logic rv, input logic [31:0] rd);
    sif.m_data_byteen = be;
    sif.m_data_addr   = addr;
    sif.m_data_wdata  = wd;
    sif.m_data_ren    = ren;
    m_gnt = gnt; m_rvalid = rv; m_rdata = rd;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset = 1'b1;
  endtask

  // Behavioural SRAM: transactions seen at negedge commit at the next edge
  logic        t_v = 1'b0, t_we = 1'b0;
  logic [2:0]  t_idx = '0;
  logic [31:0] t_data = '0, rd_val = '0;
  logic [3:0]  t_be = '0;
  int          rd_cnt = 0;

  always @(negedge clk) begin
    t_v    = auto_sram && sif.sram_req && a_gnt;
    t_we   = sif.sram_we;
    t_idx  = sif.sram_addr[2:0];
    t_data = sif.sram_wdata;
    t_be   = sif.sram_be;
  end

  always begin
    @(posedge clk);
    if (auto_sram) begin
      if (t_v) begin
        if (t_we) begin
          for (int b = 0; b < 4; b++) if (t_be[b]) sm[t_idx][8*b +: 8] = t_data[8*b +: 8];
          pops++;
        end else begin
          rd_cnt = $urandom_range(1, 3);
          rd_val = sm[t_idx];
        end
      end
      #2;
      a_rvalid = 1'b0;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin a_rvalid = 1'b1; a_rdata = rd_val; end
      end
      a_gnt = ($urandom_range(0, 1) == 1);
    end
  end

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic        gnt;
    logic        exp_stall;
    logic        exp_req;
    logic [11:0] exp_addr;
    logic        exp_empty;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] be, input logic [31:0] addr, input logic gnt,
                              input logic st, input logic rq, input logic [11:0] ea, input logic emp);
    vec_t v;
    v.be = be; v.addr = addr; v.gnt = gnt; v.exp_stall = st;
    v.exp_req = rq; v.exp_addr = ea; v.exp_empty = emp;
    return v;
  endfunction

  initial begin
    vec_t tv [12];
    int   nst;
    logic [3:0] exp_be;
    logic [15:0] exp_lo;
    logic exp_emp;

    // Fill four slots with the grant held off, stall the fifth, then drain through the wrap
    tv[0]  = mk(4'hF, 32'h00, 1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    tv[1]  = mk(4'hF, 32'h04, 1'b0, 1'b0, 1'b1, 12'h0, 1'b0);
    tv[2]  = mk(4'hF, 32'h08, 1'b0, 1'b0, 1'b1, 12'h0, 1'b0);
    tv[3]  = mk(4'hF, 32'h0C, 1'b0, 1'b0, 1'b1, 12'h0, 1'b0);
    tv[4]  = mk(4'hF, 32'h10, 1'b0, 1'b1, 1'b1, 12'h0, 1'b0);
    tv[5]  = mk(4'hF, 32'h10, 1'b1, 1'b1, 1'b1, 12'h0, 1'b0);
    tv[6]  = mk(4'hF, 32'h10, 1'b0, 1'b0, 1'b1, 12'h1, 1'b0);
    tv[7]  = mk(4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 12'h1, 1'b0);
    tv[8]  = mk(4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 12'h2, 1'b0);
    tv[9]  = mk(4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 12'h3, 1'b0);
    tv[10] = mk(4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 12'h4, 1'b0);
    tv[11] = mk(4'h0, 32'h00, 1'b0, 1'b0, 1'b0, 12'h0, 1'b1);

    // Reset state, with and without a load pending during reset
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_stall", 32'(sif.m_stall), 32'd0);
    chk("rst_req", 32'(sif.sram_req), 32'd0);
    chk("rst_empty", 32'(sif.stb_empty), 32'd1);
    chk("rst_rdata", sif.m_data_rdata, 32'd0);
    step();
    drive(4'h0, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_ren_req", 32'(sif.sram_req), 32'd1);
    chk("rst_ren_we", 32'(sif.sram_we), 32'd0);
    chk("rst_ren_addr", 32'(sif.sram_addr), 32'h80);
    chk("rst_ren_stall", 32'(sif.m_stall), 32'd1);
    step();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].be, tv[i].addr, 32'hD000_0000 | (tv[i].addr >> 2), 1'b0, tv[i].gnt, 1'b0, 32'h0);
      chk($sformatf("tab%0d_stall", i), 32'(sif.m_stall), 32'(tv[i].exp_stall));
      chk($sformatf("tab%0d_req", i), 32'(sif.sram_req), 32'(tv[i].exp_req));
      chk($sformatf("tab%0d_empty", i), 32'(sif.stb_empty), 32'(tv[i].exp_empty));
      if (tv[i].exp_req) begin
        chk($sformatf("tab%0d_addr", i), 32'(sif.sram_addr), 32'(tv[i].exp_addr));
        chk($sformatf("tab%0d_wdata", i), sif.sram_wdata, 32'hD000_0000 | 32'(tv[i].exp_addr));
        chk($sformatf("tab%0d_we", i), 32'(sif.sram_we), 32'd1);
      end
      step();
    end

    // Load behind a buffered store to the same word
    drive(4'hF, 32'h20, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("haz_st_stall", 32'(sif.m_stall), 32'd0);
    step();
    drive(4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("haz_stall0", 32'(sif.m_stall), 32'd1);
    chk("haz_drain_we", 32'(sif.sram_we), 32'd1);
    chk("haz_drain_addr", 32'(sif.sram_addr), 32'h8);
    step();
    drive(4'h0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("haz_stall1", 32'(sif.m_stall), 32'd1);
    step();
    drive(4'h0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("haz_rd_req", 32'(sif.sram_req), 32'd1);
    chk("haz_rd_we", 32'(sif.sram_we), 32'd0);
    chk("haz_rd_be", 32'(sif.sram_be), 32'hF);
    chk("haz_stall2", 32'(sif.m_stall), 32'd1);
    step();
    drive(4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'hAABBCCDD);
    chk("haz_wait_req", 32'(sif.sram_req), 32'd0);
    chk("haz_stall3", 32'(sif.m_stall), 32'd1);
    step();
    drive(4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("haz_done_stall", 32'(sif.m_stall), 32'd0);
    chk("haz_rdata", sif.m_data_rdata, 32'hAABBCCDD);
    step();
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("haz_rdata_hold", sif.m_data_rdata, 32'hAABBCCDD);
    step();

    // Clean load with rvalid three cycles after the grant
    nst = 0;
    for (int k = 0; k < 12; k++) begin
      drive(4'h0, 32'h40, 32'h0, 1'b1, 1'(k == 0), 1'(k == 3), 32'h13579BDF);
      if (k == 0) chk("ld_addr", 32'(sif.sram_addr), 32'h10);
      if (!sif.m_stall) begin
        chk("ld_rdata", sif.m_data_rdata, 32'h13579BDF);
        step();
        break;
      end
      nst++;
      step();
    end
    chk("ld_stall_cycles", 32'(nst), 32'd4);

    // Reset while a read is outstanding and two stores are buffered
    drive(4'hF, 32'h50, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(4'hF, 32'h54, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(4'h0, 32'h60, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("ro_rd_prio_we", 32'(sif.sram_we), 32'd0);
    step();
    drive(4'h0, 32'h60, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("ro_wait_nodrain", 32'(sif.sram_req), 32'd0);
    chk("ro_wait_empty", 32'(sif.stb_empty), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("ro_empty", 32'(sif.stb_empty), 32'd1);
    chk("ro_rdata", sif.m_data_rdata, 32'd0);
    chk("ro_req", 32'(sif.sram_req), 32'd0);
    step();
    drive(4'h0, 32'h70, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("ro_idle_req", 32'(sif.sram_req), 32'd1);
    chk("ro_idle_we", 32'(sif.sram_we), 32'd0);
    chk("ro_late_rvalid", sif.m_data_rdata, 32'd0);
    step();
    reset_pulse();

    // Two partial stores to one word: merged into a single entry when merging is built in
`ifdef DM_STB_MERGE_EN
    exp_be = 4'b0011; exp_lo = 16'h2211; exp_emp = 1'b1;
`else
    exp_be = 4'b0001; exp_lo = 16'h0011; exp_emp = 1'b0;
`endif
    drive(4'b0001, 32'h30, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(4'b0010, 32'h30, 32'h0000_2200, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mrg_stall", 32'(sif.m_stall), 32'd0);
    step();
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("mrg_be", 32'(sif.sram_be), 32'(exp_be));
    chk("mrg_lo", 32'(sif.sram_wdata[15:0]), 32'(exp_lo));
    chk("mrg_addr", 32'(sif.sram_addr), 32'hC);
    step();
    drive(4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("mrg_empty", 32'(sif.stb_empty), 32'(exp_emp));
    step();
    reset_pulse();

    // Random program against the flat memory model
    for (int i = 0; i < 8; i++) begin
      sm[i] = $urandom;
      gm[i] = sm[i];
    end
    auto_sram = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic       is_ld, done;
      int         idx, waited;
      logic [3:0] be;
      logic [31:0] wd;
      is_ld = ($urandom_range(0, 2) == 0);
      idx   = $urandom_range(0, 7);
      be    = is_ld ? 4'h0 : 4'($urandom_range(1, 15));
      wd    = $urandom;
      sif.m_data_addr   = 32'h100 + 32'(idx * 4);
      sif.m_data_byteen = be;
      sif.m_data_wdata  = wd;
      sif.m_data_ren    = is_ld;
      done = 1'b0;
      waited = 0;
      while (!done) begin
        @(negedge clk);
`ifndef DM_STB_MERGE_EN
        if (!is_ld) chk("rnd_st_stall", 32'(sif.m_stall), 32'((pushes - pops) == DEPTH));
`endif
        if (!sif.m_stall) begin
          done = 1'b1;
          if (is_ld) chk($sformatf("rnd_ld%0d", n), sif.m_data_rdata, gm[idx]);
          else begin
            for (int b = 0; b < 4; b++) if (be[b]) gm[idx][8*b +: 8] = wd[8*b +: 8];
            pushes++;
          end
        end else if (++waited > 100) begin
          chk($sformatf("rnd_timeout%0d", n), 32'd1, 32'd0);
          done = 1'b1;
        end
        step();
      end
      sif.m_data_byteen = 4'h0;
      sif.m_data_ren    = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    for (int w = 0; w < 200 && !sif.stb_empty; w++) step();
    chk("rnd_drained", 32'(sif.stb_empty), 32'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("rnd_mem%0d", i), sm[i], gm[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/dm_store_resp.md
# dm_store_resp

Data-side memory responder that services the CPU core's data port (`m_data_addr` / `m_data_wdata` / `m_data_byteen` / `m_data_rdata`) and connects it to a single-port, word-wide backing SRAM with grant/valid handshakes.

- Stores are absorbed into a DEPTH-entry store buffer and drained in the background, so stores do not wait for the SRAM.
- Loads run through a read FSM.
- The block asserts `m_stall` whenever it cannot complete the current access in this cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of store-buffer entries; must be a power of two, at least 2.
- `ADDR_W`, 12: SRAM word-address width. The word address is `m_data_addr[ADDR_W+1:2]`.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low reset. Sampled at the rising edge of `clk`.
- `m_data_addr`, in, 32: byte address of the access. Bits [1:0] are ignored; lane selection is carried by `m_data_byteen`.
- `m_data_wdata`, in, 32: store data, already shifted into its byte lanes.
- `m_data_byteen`, in, 4: store byte enables. Any nonzero value is a store request.
- `m_data_ren`, in, 1: load request for a full word.
- `m_data_rdata`, out, 32: load data. Valid in the cycle a load completes.
- `m_stall`, out, 1: the current request is not accepted this cycle. The CPU holds every request input stable while this is high.
- `sram_req`, out, 1: SRAM request.
- `sram_we`, out, 1: 1 for a write, 0 for a read.
- `sram_addr`, out, ADDR_W: SRAM word address.
- `sram_wdata`, out, 32: SRAM write data.
- `sram_be`, out, 4: SRAM byte enables.
- `sram_gnt`, in, 1: the request is accepted in any cycle where `sram_req` and `sram_gnt` are both high.
- `sram_rvalid`, in, 1: read data is valid. Arrives at least 1 cycle after the read grant.
- `sram_rdata`, in, 32: SRAM read data.
- `stb_empty`, out, 1: the store buffer holds no entries.

## Operation
Store buffer:
- Circular FIFO of {word address, data, byteen} entries, with head pointer, tail pointer and count.
- A store is accepted at the clock edge when `m_data_byteen` is nonzero and `m_stall` is low; it is pushed at the tail.
- A store while the buffer is full stalls until a slot frees.

Read FSM, states IDLE, RD_WAIT, RD_DONE:
- Hazard condition: the load's word address equals the address of any valid buffer entry.
- IDLE:
  - If `m_data_ren` is high and there is no hazard, the SRAM port is driven with the read (`sram_we`=0, `sram_be`=4'hF).
  - On grant, go to RD_WAIT.
  - While the hazard holds, the buffer keeps draining and the load stalls.
- RD_WAIT: on `sram_rvalid`, register `sram_rdata` into `m_data_rdata` and go to RD_DONE.
- RD_DONE: the load completes this cycle (`m_stall`=0). Return to IDLE unconditionally.

SRAM port arbitration:
- A read issuing from IDLE has priority.
- Otherwise, in IDLE with the buffer non-empty, the head entry is presented (`sram_we`=1, with its address, data and byteen).
- A granted write pops the head.
- No drain happens in RD_WAIT or RD_DONE.

`m_stall` definition:
- (`m_data_ren` and state ≠ RD_DONE) or (store request and buffer full and no merge).

Illegal input: `m_data_ren` and a nonzero `m_data_byteen` together. Behaviour is undefined and the bench never drives it.

## Timing
- Reset values:
  - FSM in IDLE, count 0, pointers 0.
  - `m_data_rdata`=0, `stb_empty`=1.
  - `sram_req`=0 unless `m_data_ren` is high.
  - `m_stall` follows its equation using the reset state.
- Reset mid-operation:
  - Buffered stores are discarded.
  - An outstanding read is abandoned. A `sram_rvalid` arriving after reset is ignored because the FSM is in IDLE.
- Store latency: 0 stall cycles when the buffer is not full. Entry becomes visible (count incremented) at the next edge.
- Minimum load latency: grant in the first cycle, `rvalid` one cycle later, completion in RD_DONE. That is 2 stall cycles, with completion on the 3rd cycle.
- Push and pop in the same edge: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- Full with a pop in the same cycle: the store still stalls. The full test uses registered count.
- `m_data_rdata` holds its value until the next read completes.

## Configuration
Macro `DM_STB_MERGE_EN`:
- Defined: a store whose word address equals the tail-most valid entry is merged into that entry, not given a new slot.
  - Bytes with enable set overwrite the entry's data.
  - The entry's byteen becomes the OR of old and new enables.
  - Merge is legal even when the buffer is full, and then does not stall.
  - Merge is suppressed when that entry is the head being popped this same cycle. The store then allocates normally, or stalls if full.
- Undefined: every store allocates a new entry and no merge logic exists.

## Test plan
- Four stores to words 0x0, 0x4, 0x8, 0xC with `sram_gnt` held at 0: no stall. A 5th store to 0x10 stalls until `sram_gnt`=1 pops the 0x0 entry.
- Store 0xAABBCCDD to 0x20 with byteen 4'hF, then immediately load 0x20 with `rvalid` 1 cycle after grant: the load stalls until the write is granted, then returns 0xAABBCCDD after the read round trip.
- Load from 0x40 with an empty buffer and a 3-cycle `rvalid` delay: `m_stall` is high for 4 cycles, then `m_data_rdata` equals `sram_rdata` while `m_stall` is low.
- With `DM_STB_MERGE_EN`: store byte 0x11 (byteen 4'b0001) then 0x22<<8 (byteen 4'b0010) to 0x30: one entry, byteen 4'b0011, and the drained write shows `sram_be`=4'b0011, data[15:0]=0x2211.
- Reset low while in RD_WAIT with 2 buffered entries: next cycle `stb_empty`=1, state IDLE, `m_data_rdata`=0, and a late `sram_rvalid` has no effect.
